dadda_signed_mac_8: RTL and testbench

Pipelined signed multiply-accumulate stage that sits directly downstream of `dadda_signed_multiplier_8`. It registers streaming 8-bit signed operand pairs and forms each 16-bit product through one internal instance of that multiplier. It then accumulates `VEC_LEN` consecutive products into one dot-product result, which it presents on a valid/ready output port. It turns the combinational multiplier into a streaming datapath block with backpressure.

---
 rtl/dadda_signed_mac_8.sv | 265 ++++++++++++++++++++++++++
 tb/tb_dadda_signed_mac_8.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_signed_mac_8.sv
`default_nettype none
// ============================================================================
//  Module   : dadda_signed_multiplier_8 / dadda_signed_mac_8
//  Brief    : Combinational 8x8 signed Dadda-tree multiplier, and a pipelined
//             signed multiply-accumulate stage built on it. The MAC sums
//             VEC_LEN products into a dot product, flags signed overflow and
//             presents each result on a valid/ready port with backpressure.
//  Revision : 1.0 - initial release
// ============================================================================

module dadda_signed_multiplier_8 (
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_p
);

    // Baugh-Wooley partial products, Dadda reduction to two rows, final add.
    // The bit matrix is indexed [column][row]; all unused rows stay 0.
    function automatic logic [15:0] f_dadda_product(input logic [7:0] a,
                                                    input logic [7:0] b);
        logic        mat [16][16];
        logic        nxt [16][16];
        int          hgt [16];
        int          nh  [16];
        int          ptr;
        int          ht;
        int          lim;
        logic        x0;
        logic        x1;
        logic        x2;
        logic        s_bit;
        logic        c_bit;
        logic [15:0] row0;
        logic [15:0] row1;

        for (int c = 0; c < 16; c++) begin
            hgt[4'(c)] = 0;
            nh[4'(c)]  = 0;
            for (int r = 0; r < 16; r++) begin
                mat[4'(c)][4'(r)] = 1'b0;
                nxt[4'(c)][4'(r)] = 1'b0;
            end
        end
        ptr   = 0;
        ht    = 0;
        lim   = 0;
        x0    = 1'b0;
        x1    = 1'b0;
        x2    = 1'b0;
        s_bit = 1'b0;
        c_bit = 1'b0;
        row0  = '0;
        row1  = '0;

        // Partial products: terms mixing exactly one sign bit are inverted,
        // and the correction constants 2^8 and 2^15 are added below.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                x0 = a[3'(j)] & b[3'(i)];
                if ((i == 7) != (j == 7)) begin
                    x0 = ~x0;
                end
                mat[4'(i + j)][4'(hgt[4'(i + j)])] = x0;
                hgt[4'(i + j)] = hgt[4'(i + j)] + 1;
            end
        end
        mat[4'd8][4'(hgt[4'd8])]   = 1'b1;
        hgt[4'd8]                  = hgt[4'd8] + 1;
        mat[4'd15][4'(hgt[4'd15])] = 1'b1;
        hgt[4'd15]                 = hgt[4'd15] + 1;

        // Dadda stages with column height limits 6, 4, 3, 2. Carries entering
        // a column count towards its height before that column is reduced.
        for (int s = 0; s < 4; s++) begin
            lim = (s == 0) ? 6 : (s == 1) ? 4 : (s == 2) ? 3 : 2;
            for (int c = 0; c < 16; c++) begin
                nh[4'(c)] = 0;
                for (int r = 0; r < 16; r++) begin
                    nxt[4'(c)][4'(r)] = 1'b0;
                end
            end
            for (int c = 0; c < 16; c++) begin
                ptr = 0;
                for (int k = 0; k < 8; k++) begin
                    ht = hgt[4'(c)] - ptr + nh[4'(c)];
                    if (ht > lim) begin
                        x0 = mat[4'(c)][4'(ptr)];
                        x1 = mat[4'(c)][4'(ptr + 1)];
                        if (ht == lim + 1) begin
                            s_bit = x0 ^ x1;
                            c_bit = x0 & x1;
                            ptr   = ptr + 2;
                        end else begin
                            x2    = mat[4'(c)][4'(ptr + 2)];
                            s_bit = x0 ^ x1 ^ x2;
                            c_bit = (x0 & x1) | (x0 & x2) | (x1 & x2);
                            ptr   = ptr + 3;
                        end
                        nxt[4'(c)][4'(nh[4'(c)])] = s_bit;
                        nh[4'(c)] = nh[4'(c)] + 1;
                        // Carry out of column 15 is beyond the 16-bit result.
                        if (c < 15) begin
                            nxt[4'(c + 1)][4'(nh[4'(c + 1)])] = c_bit;
                            nh[4'(c + 1)] = nh[4'(c + 1)] + 1;
                        end
                    end
                end
                for (int r = 0; r < 16; r++) begin
                    if (r >= ptr && r < hgt[4'(c)]) begin
                        nxt[4'(c)][4'(nh[4'(c)])] = mat[4'(c)][4'(r)];
                        nh[4'(c)] = nh[4'(c)] + 1;
                    end
                end
            end
            for (int c = 0; c < 16; c++) begin
                hgt[4'(c)] = nh[4'(c)];
                for (int r = 0; r < 16; r++) begin
                    mat[4'(c)][4'(r)] = nxt[4'(c)][4'(r)];
                end
            end
        end

        for (int c = 0; c < 16; c++) begin
            row0[4'(c)] = mat[4'(c)][4'd0];
            row1[4'(c)] = mat[4'(c)][4'd1];
        end
        return row0 + row1;
    endfunction

    // Product of the two signed operands, modulo 2^16.
    always_comb begin
        o_p = f_dadda_product(i_a, i_b);
    end

endmodule

module dadda_signed_mac_8 #(
    parameter int ACC_W   = 24,
    parameter int VEC_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam int                c_CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(VEC_LEN - 1);

    logic [7:0]         r_a_q,         w_a_d;
    logic [7:0]         r_b_q,         w_b_d;
    logic               r_o_valid_q,   w_o_valid_d;
    logic [15:0]        r_p_q,         w_p_d;
    logic               r_p_valid_q,   w_p_valid_d;
    logic [ACC_W-1:0]   r_acc_q,       w_acc_d;
    logic [c_CNT_W-1:0] r_cnt_q,       w_cnt_d;
    logic               r_seen_q,      w_seen_d;
    logic [ACC_W-1:0]   r_out_acc_q,   w_out_acc_d;
    logic               r_out_ovf_q,   w_out_ovf_d;
    logic               r_out_valid_q, w_out_valid_d;

    logic               w_en;
    logic [15:0]        w_prod;
    logic [ACC_W-1:0]   w_p_ext;
    logic [ACC_W-1:0]   w_sum;
    logic               w_ovf_now;
    logic               w_last;

    dadda_signed_multiplier_8 u_mul (
        .i_a (r_a_q),
        .i_b (r_b_q),
        .o_p (w_prod)
    );

    // Advance enable, accumulation arithmetic and next state of every stage.
    always_comb begin
        w_en      = !(r_out_valid_q && !out_ready);
        w_p_ext   = ACC_W'($signed(r_p_q));
        w_sum     = r_acc_q + w_p_ext;
        w_ovf_now = (r_acc_q[ACC_W-1] == w_p_ext[ACC_W-1]) &&
                    (w_sum[ACC_W-1] != r_acc_q[ACC_W-1]);
        w_last    = (r_cnt_q == c_LAST);

        w_a_d         = r_a_q;
        w_b_d         = r_b_q;
        w_o_valid_d   = r_o_valid_q;
        w_p_d         = r_p_q;
        w_p_valid_d   = r_p_valid_q;
        w_acc_d       = r_acc_q;
        w_cnt_d       = r_cnt_q;
        w_seen_d      = r_seen_q;
        w_out_acc_d   = r_out_acc_q;
        w_out_ovf_d   = r_out_ovf_q;
        w_out_valid_d = r_out_valid_q;

        // A consumed result drops out_valid unless a new one lands below.
        if (r_out_valid_q && out_ready) begin
            w_out_valid_d = 1'b0;
        end

        if (w_en) begin
            w_a_d       = in_a;
            w_b_d       = in_b;
            w_o_valid_d = in_valid;
            w_p_d       = w_prod;
            w_p_valid_d = r_o_valid_q;
            if (r_p_valid_q) begin
                if (w_last) begin
                    w_out_acc_d   = w_sum;
                    w_out_ovf_d   = r_seen_q | w_ovf_now;
                    w_out_valid_d = 1'b1;
                    w_acc_d       = '0;
                    w_cnt_d       = '0;
                    w_seen_d      = 1'b0;
                end else begin
                    w_acc_d  = w_sum;
                    w_cnt_d  = r_cnt_q + c_CNT_W'(1);
                    w_seen_d = r_seen_q | w_ovf_now;
                end
            end
        end
    end

    // State registers; reset discards partial sums and in-flight pairs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_q         <= '0;
            r_b_q         <= '0;
            r_o_valid_q   <= 1'b0;
            r_p_q         <= '0;
            r_p_valid_q   <= 1'b0;
            r_acc_q       <= '0;
            r_cnt_q       <= '0;
            r_seen_q      <= 1'b0;
            r_out_acc_q   <= '0;
            r_out_ovf_q   <= 1'b0;
            r_out_valid_q <= 1'b0;
        end else begin
            r_a_q         <= w_a_d;
            r_b_q         <= w_b_d;
            r_o_valid_q   <= w_o_valid_d;
            r_p_q         <= w_p_d;
            r_p_valid_q   <= w_p_valid_d;
            r_acc_q       <= w_acc_d;
            r_cnt_q       <= w_cnt_d;
            r_seen_q      <= w_seen_d;
            r_out_acc_q   <= w_out_acc_d;
            r_out_ovf_q   <= w_out_ovf_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    assign in_ready  = w_en;
    assign out_valid = r_out_valid_q;
    assign out_acc   = r_out_acc_q;
    assign out_ovf   = r_out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dadda_signed_mac_8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dadda_signed_mac_8
//  Brief    : Directed bench for dadda_signed_mac_8 in three configurations
//             (24/4, 16/2, 24/1) with a per-instance result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dadda_signed_mac_8;

    typedef struct {
        int   acc;
        logic ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_ovf_a;
    logic [7:0]  in_a_a, in_b_a;
    logic [23:0] out_acc_a;
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_ovf_b;
    logic [7:0]  in_a_b, in_b_b;
    logic [15:0] out_acc_b;
    logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_ovf_c;
    logic [7:0]  in_a_c, in_b_c;
    logic [23:0] out_acc_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t e_a, e_b, e_c;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dadda_signed_mac_8 #(.ACC_W(24), .VEC_LEN(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_a(in_a_a), .in_b(in_b_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_acc(out_acc_a), .out_ovf(out_ovf_a));

    dadda_signed_mac_8 #(.ACC_W(16), .VEC_LEN(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_a(in_a_b), .in_b(in_b_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_acc(out_acc_b), .out_ovf(out_ovf_b));

    dadda_signed_mac_8 #(.ACC_W(24), .VEC_LEN(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_a(in_a_c), .in_b(in_b_c), .out_valid(out_valid_c),
        .out_ready(out_ready_c), .out_acc(out_acc_c), .out_ovf(out_ovf_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? in_ready_a : (d == 1) ? in_ready_b : in_ready_c;
    endfunction

    function automatic logic vld(input int d);
        return (d == 0) ? out_valid_a : (d == 1) ? out_valid_b : out_valid_c;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q_a.size() : (d == 1) ? q_b.size() : q_c.size();
    endfunction

    task automatic push(input int d, input int acc, input logic ovf);
        exp_t e;
        e.acc = acc;
        e.ovf = ovf;
        case (d)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic set_in(input int d, input logic v, input int a, input int b);
        case (d)
            0:       begin in_valid_a = v; in_a_a = 8'(a); in_b_a = 8'(b); end
            1:       begin in_valid_b = v; in_a_b = 8'(a); in_b_b = 8'(b); end
            default: begin in_valid_c = v; in_a_c = 8'(a); in_b_c = 8'(b); end
        endcase
    endtask

    // Present a pair and hold it until the edge that accepts it.
    task automatic send(input int d, input int a, input int b);
        logic ok;
        ok = 1'b0;
        set_in(d, 1'b1, a, b);
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = rdy(d);
        end
        chk("pair_accepted", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        set_in(d, 1'b0, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int d, input int max, output logic ok);
        ok = 1'b0;
        for (int t = 0; t < max && !ok; t++) begin
            @(negedge clk);
            ok = vld(d);
        end
    endtask

    task automatic drain(input int d, input string tag);
        for (int t = 0; t < 100 && qsize(d) != 0; t++) @(negedge clk);
        chk(tag, 32'(qsize(d)), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: a result is checked on the cycle it is handed over.
    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready_a) begin
            chk("a_result_expected", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                e_a = q_a.pop_front();
                chk("a_out_acc", 32'($signed(out_acc_a)), e_a.acc);
                chk("a_out_ovf", 32'(out_ovf_a), 32'(e_a.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_b && out_ready_b) begin
            chk("b_result_expected", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                e_b = q_b.pop_front();
                chk("b_out_acc", 32'($signed(out_acc_b)), e_b.acc);
                chk("b_out_ovf", 32'(out_ovf_b), 32'(e_b.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_c && out_ready_c) begin
            chk("c_result_expected", 32'(q_c.size() != 0), 32'd1);
            if (q_c.size() != 0) begin
                e_c = q_c.pop_front();
                chk("c_out_acc", 32'($signed(out_acc_c)), e_c.acc);
                chk("c_out_ovf", 32'(out_ovf_c), 32'(e_c.ovf));
            end
        end
    end

    initial begin
        logic ok;
        set_in(0, 1'b0, 0, 0);
        set_in(1, 1'b0, 0, 0);
        set_in(2, 1'b0, 0, 0);
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;
        out_ready_c = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_in_ready_a",  32'(in_ready_a),  32'd1);
        chk("rst_out_valid_a", 32'(out_valid_a), 32'd0);
        chk("rst_out_acc_a",   32'(out_acc_a),   32'd0);
        chk("rst_out_ovf_a",   32'(out_ovf_a),   32'd0);
        chk("rst_out_valid_b", 32'(out_valid_b), 32'd0);
        chk("rst_out_valid_c", 32'(out_valid_c), 32'd0);
        idle(1);

        // Normal vector with latency and single-pulse checks.
        push(0, -14634, 1'b0);
        send(0, 98, 115);
        send(0, -86, 99);
        send(0, -27, 42);
        send(0, 127, -128);
        @(negedge clk); chk("lat_k0_valid", 32'(out_valid_a), 32'd0);
        @(negedge clk); chk("lat_k1_valid", 32'(out_valid_a), 32'd0);
        @(negedge clk); chk("lat_k2_valid", 32'(out_valid_a), 32'd1);
        @(negedge clk); chk("lat_k3_valid", 32'(out_valid_a), 32'd0);
        drain(0, "normal_drained");

        // Backpressure: two vectors, first result held for 5 cycles.
        out_ready_a = 1'b0;
        push(0, -14634, 1'b0);
        push(0, -14634, 1'b0);
        fork
            begin
                for (int v = 0; v < 2; v++) begin
                    send(0, 98, 115);
                    send(0, -86, 99);
                    send(0, -27, 42);
                    send(0, 127, -128);
                end
            end
            begin
                wait_valid(0, 50, ok);
                chk("bp_first_result", 32'(ok), 32'd1);
                for (int t = 0; t < 5; t++) begin
                    if (t != 0) @(negedge clk);
                    chk("bp_in_ready",  32'(in_ready_a),             32'd0);
                    chk("bp_out_acc",   32'($signed(out_acc_a)),     -32'sd14634);
                    chk("bp_out_valid", 32'(out_valid_a),            32'd1);
                end
                @(posedge clk);
                #1;
                out_ready_a = 1'b1;
            end
        join
        drain(0, "bp_drained");

        // Overflow with wrap-around, then a clean vector.
        push(1, -32768, 1'b1);
        push(1, 2, 1'b0);
        send(1, -128, -128);
        send(1, -128, -128);
        send(1, 1, 1);
        send(1, 1, 1);
        drain(1, "ovf_drained");

        // Streaming with VEC_LEN=1: one result per cycle.
        for (int i = 1; i <= 8; i++) push(2, -(i * i), 1'b0);
        fork
            begin
                for (int i = 1; i <= 8; i++) send(2, i, -i);
            end
            begin
                wait_valid(2, 50, ok);
                chk("stream_first_result", 32'(ok), 32'd1);
                for (int t = 1; t < 8; t++) begin
                    @(negedge clk);
                    chk("stream_back_to_back", 32'(out_valid_c), 32'd1);
                end
            end
        join
        drain(2, "stream_drained");

        // Vector spread across bubbles.
        push(0, 69, 1'b0);
        send(0, 2, 3);
        idle(2);
        send(0, 4, 5);
        idle(1);
        send(0, -1, 6);
        send(0, 7, 7);
        drain(0, "gaps_drained");
        idle(6);

        // Reset mid-vector discards the partial sum and in-flight pairs.
        send(0, 10, 10);
        send(0, 10, 10);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid_a), 32'd0);
        idle(1);
        push(0, 100, 1'b0);
        send(0, 1, 2);
        send(0, 3, 4);
        send(0, 5, 6);
        send(0, 7, 8);
        drain(0, "midrst_drained");

        // Nothing extra may appear afterwards.
        idle(8);
        chk("final_q_a", 32'(q_a.size()), 32'd0);
        chk("final_q_b", 32'(q_b.size()), 32'd0);
        chk("final_q_c", 32'(q_c.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
